// File: rtl/seg7_scan_driver.sv
// Purpose : time-multiplexed driver for a 4-digit common-anode 7-segment display (MM:SS BCD).
// Latency : an/seg/dp/frame_tick are registered, one clk after the scan state they reflect.
// Backpr. : none; free-running scan, time_data is sampled once per frame and never stalls.
//
// Ports
//   clk         system clock
//   reset       synchronous, active-high reset
//   time_data   BCD word {d3,d2,d1,d0}, d0 = units of seconds
//   display_en  0 blanks the display; scan counters and latching continue
//   an          anode enables, active low, an[i] drives digit i
//   seg         segments {g,f,e,d,c,b,a}, active low
//   dp          decimal point, active low
//   frame_tick  one-cycle pulse marking the last cycle of each 4-digit frame

module seg7_scan_driver #(
   parameter int unsigned REFRESH_DIV   = 100000,
   parameter int unsigned GHOST_CYCLES  = 1000,
   parameter bit          BLANK_LEADING = 1'b1,
   parameter int unsigned DP_DIGIT      = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] time_data,
   input  logic        display_en,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        frame_tick
);

   localparam int unsigned CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

   localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] GHOST_TH  = CNT_W'(GHOST_CYCLES);
   localparam logic [1:0]       DP_IDX    = 2'(DP_DIGIT);

   localparam logic [3:0] AN_OFF  = 4'hF;
   localparam logic [6:0] SEG_OFF = 7'h7F;

   // Scan state
   logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
   logic [1:0]       digit_idx_q, digit_idx_d;
   logic [15:0]      shadow_q, shadow_d;

   // Registered outputs
   logic [3:0]       an_q, an_d;
   logic [6:0]       seg_q, seg_d;
   logic             dp_q, dp_d;
   logic             frame_tick_q, frame_tick_d;

   logic             slot_last;
   logic             frame_last;
   logic [3:0]       nibble;

   // BCD to active-low segments; anything above 9 renders as a dash.
   function automatic logic [6:0] enc(input logic [3:0] val);
      logic [6:0] s;
      case (val)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = 7'h3F;
      endcase
      return s;
   endfunction

   assign slot_last  = (tick_cnt_q == TICK_LAST);
   assign frame_last = slot_last && (digit_idx_q == 2'd3);

   // Scan counters and frame-synchronous latch. The shadow word only changes
   // on the final cycle of digit 3, so a frame never mixes two time values.
   always_comb begin
      tick_cnt_d  = tick_cnt_q + CNT_W'(1);
      digit_idx_d = digit_idx_q;
      shadow_d    = shadow_q;
      if (slot_last) begin
         tick_cnt_d  = '0;
         digit_idx_d = digit_idx_q + 2'd1;
      end
      if (frame_last) begin
         shadow_d = time_data;
      end
   end

   always_comb begin
      case (digit_idx_q)
         2'd0:    nibble = shadow_q[3:0];
         2'd1:    nibble = shadow_q[7:4];
         2'd2:    nibble = shadow_q[11:8];
         default: nibble = shadow_q[15:12];
      endcase
   end

   // Output decode. The first GHOST_CYCLES of every slot keep all anodes off
   // so the previous digit's segments cannot bleed into the new digit.
   always_comb begin
      an_d         = AN_OFF;
      seg_d        = SEG_OFF;
      dp_d         = 1'b1;
      frame_tick_d = frame_last;
      if (display_en && (tick_cnt_q >= GHOST_TH)) begin
         an_d = ~(4'b0001 << digit_idx_q);
         // Leading-zero blanking keeps the anode driven with all segments off,
         // which preserves the per-digit duty cycle.
         if (!(BLANK_LEADING && (digit_idx_q == 2'd3) && (nibble == 4'd0))) begin
            seg_d = enc(nibble);
            dp_d  = (digit_idx_q != DP_IDX);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tick_cnt_q   <= '0;
         digit_idx_q  <= 2'd0;
         shadow_q     <= 16'h0000;
         an_q         <= AN_OFF;
         seg_q        <= SEG_OFF;
         dp_q         <= 1'b1;
         frame_tick_q <= 1'b0;
      end else begin
         tick_cnt_q   <= tick_cnt_d;
         digit_idx_q  <= digit_idx_d;
         shadow_q     <= shadow_d;
         an_q         <= an_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   assign an         = an_q;
   assign seg        = seg_q;
   assign dp         = dp_q;
   assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Purpose : self-checking bench for seg7_scan_driver (blanking and non-blanking instances).
// Latency : expected outputs are derived from the scan position one cycle earlier.
// Backpr. : none; stimulus is applied every cycle.

module tb_seg7_scan_driver;

   localparam int RD    = 8;
   localparam int GC    = 2;
   localparam int DPD   = 2;
   localparam int FRAME = 4 * RD;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] time_data;
   logic        display_en;
   logic [3:0]  an,  an0;
   logic [6:0]  seg, seg0;
   logic        dp,  dp0;
   logic        frame_tick, frame_tick0;

   always #5 clk = ~clk;

   seg7_scan_driver #(
      .REFRESH_DIV(RD), .GHOST_CYCLES(GC), .BLANK_LEADING(1'b1), .DP_DIGIT(DPD)
   ) dut (
      .clk(clk), .reset(reset), .time_data(time_data), .display_en(display_en),
      .an(an), .seg(seg), .dp(dp), .frame_tick(frame_tick)
   );

   seg7_scan_driver #(
      .REFRESH_DIV(RD), .GHOST_CYCLES(GC), .BLANK_LEADING(1'b0), .DP_DIGIT(DPD)
   ) dut_nb (
      .clk(clk), .reset(reset), .time_data(time_data), .display_en(display_en),
      .an(an0), .seg(seg0), .dp(dp0), .frame_tick(frame_tick0)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, act, exp);
      end
   endtask

   // Reference model: the scan position is just "cycles since reset" modulo
   // the frame length; the displayed word is whatever was sampled at the last
   // frame boundary.
   logic [6:0]  enc_tab [16];
   int          m_n;
   logic [15:0] m_sh;
   bit          m_valid = 1'b0;
   logic [3:0]  e_an;
   logic [6:0]  e_seg, e_seg0;
   logic        e_dp, e_dp0, e_ft;

   task automatic model_step();
      int         p, slot, w;
      logic [3:0] d;
      logic [3:0] onehot;
      if (reset) begin
         m_n = 0; m_sh = 16'h0000; m_valid = 1'b1;
         e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_seg0 = 7'h7F; e_dp0 = 1'b1; e_ft = 1'b0;
      end else if (m_valid) begin
         p    = m_n % FRAME;
         slot = p / RD;
         w    = p % RD;
         e_ft = (p == FRAME - 1);
         e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_seg0 = 7'h7F; e_dp0 = 1'b1;
         if (display_en && w >= GC) begin
            onehot = 4'b0001 << slot;
            e_an   = ~onehot;
            d      = m_sh[slot*4 +: 4];
            e_seg0 = enc_tab[d];
            e_dp0  = (slot == DPD) ? 1'b0 : 1'b1;
            if (slot == 3 && d == 4'd0) begin
               e_seg = 7'h7F; e_dp = 1'b1;
            end else begin
               e_seg = e_seg0; e_dp = e_dp0;
            end
         end
         if (p == FRAME - 1) m_sh = time_data;
         m_n++;
      end
   endtask

   // One clock: drive inputs away from the edge, update the model on the edge,
   // compare both instances on the falling edge.
   task automatic cycle(input logic r, input logic [15:0] td, input logic en);
      reset = r; time_data = td; display_en = en;
      @(posedge clk);
      model_step();
      @(negedge clk);
      if (m_valid) begin
         chk("an",       an,          e_an);
         chk("seg",      seg,         e_seg);
         chk("dp",       dp,          e_dp);
         chk("ft",       frame_tick,  e_ft);
         chk("an_nb",    an0,         e_an);
         chk("seg_nb",   seg0,        e_seg0);
         chk("dp_nb",    dp0,         e_dp0);
         chk("ft_nb",    frame_tick0, e_ft);
         chk("an_onehot", ($countones(~an) <= 1), 1);
      end
   endtask

   task automatic align(input logic [15:0] td);
      bit found = 1'b0;
      for (int i = 0; i < 2 * FRAME && !found; i++) begin
         cycle(1'b0, td, 1'b1);
         if (frame_tick === 1'b1) found = 1'b1;
      end
      chk("align_frame_tick", found, 1);
   endtask

   logic [6:0] cap_seg  [4];
   logic [6:0] cap_seg0 [4];
   logic       cap_dp   [4];
   int         dark_cnt, ft_cnt, ft_pos;

   // Runs exactly one frame, recording what each digit showed.
   task automatic capture(input logic [15:0] ta, input logic [15:0] tb_v, input int sw, input logic en);
      logic [3:0] sel;
      for (int d = 0; d < 4; d++) begin
         cap_seg[d] = 7'h55; cap_seg0[d] = 7'h55; cap_dp[d] = 1'b1;
      end
      dark_cnt = 0; ft_cnt = 0; ft_pos = -1;
      for (int i = 0; i < FRAME; i++) begin
         cycle(1'b0, (i < sw) ? ta : tb_v, en);
         for (int d = 0; d < 4; d++) begin
            sel = ~(4'b0001 << d);
            if (an  === sel) begin cap_seg[d]  = seg; cap_dp[d] = dp; end
            if (an0 === sel) cap_seg0[d] = seg0;
         end
         if (an === 4'hF) dark_cnt++;
         if (frame_tick === 1'b1) begin ft_cnt++; ft_pos = i; end
      end
   endtask

   initial begin
      int          first_ft;
      logic [15:0] rtd;
      logic        ren, rr;

      enc_tab[0] = 7'h40; enc_tab[1] = 7'h79; enc_tab[2] = 7'h24; enc_tab[3] = 7'h30;
      enc_tab[4] = 7'h19; enc_tab[5] = 7'h12; enc_tab[6] = 7'h02; enc_tab[7] = 7'h78;
      enc_tab[8] = 7'h00; enc_tab[9] = 7'h10;
      for (int i = 10; i < 16; i++) enc_tab[i] = 7'h3F;

      reset = 1'b1; time_data = 16'h0000; display_en = 1'b1;
      @(negedge clk);

      // 1: reset for 3 cycles, then the first frame of an all-zero shadow
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 16'h0000, 1'b1);
         chk("t1_rst_an", an, 4'hF);
         chk("t1_rst_seg", seg, 7'h7F);
         chk("t1_rst_dp", dp, 1'b1);
      end
      first_ft = -1;
      for (int i = 0; i < 40; i++) begin
         cycle(1'b0, 16'h0000, 1'b1);
         if (m_n == 2) chk("t1_dark_c2", an, 4'hF);
         if (m_n == 3) begin chk("t1_an_c3", an, 4'hE); chk("t1_seg_c3", seg, 7'h40); end
         if (m_n == 8) begin chk("t1_an_c8", an, 4'hE); chk("t1_seg_c8", seg, 7'h40); end
         if (m_n == 9) chk("t1_dark_c9", an, 4'hF);
         if (frame_tick === 1'b1 && first_ft < 0) first_ft = m_n;
      end
      chk("t1_first_ft", first_ft, 32);

      // 2: 1234
      align(16'h1234);
      capture(16'h1234, 16'h1234, FRAME, 1'b1);
      chk("t2_d0", cap_seg[0], 7'h19);
      chk("t2_d1", cap_seg[1], 7'h30);
      chk("t2_d2", cap_seg[2], 7'h24);
      chk("t2_dp2", cap_dp[2], 1'b0);
      chk("t2_d3", cap_seg[3], 7'h79);
      chk("t2_dark", dark_cnt, 8);

      // 3: 0059, leading zero blanked on one instance only
      align(16'h0059);
      capture(16'h0059, 16'h0059, FRAME, 1'b1);
      chk("t3_d3_blank", cap_seg[3], 7'h7F);
      chk("t3_dp3", cap_dp[3], 1'b1);
      chk("t3_d2", cap_seg[2], 7'h40);
      chk("t3_dp2", cap_dp[2], 1'b0);
      chk("t3_d3_noblank", cap_seg0[3], 7'h40);

      // 4: mid-frame change is deferred to the next frame
      align(16'h0001);
      capture(16'h0001, 16'h0002, 10, 1'b1);
      chk("t4_d0_old", cap_seg[0], 7'h79);
      chk("t4_d1_old", cap_seg[1], 7'h40);
      capture(16'h0002, 16'h0002, FRAME, 1'b1);
      chk("t4_d0_new", cap_seg[0], 7'h24);

      // 5: invalid BCD, then a dark frame
      align(16'h00A0);
      capture(16'h00A0, 16'h00A0, FRAME, 1'b1);
      chk("t5_dash", cap_seg[1], 7'h3F);
      capture(16'h00A0, 16'h00A0, FRAME, 1'b0);
      chk("t5_dark_all", dark_cnt, FRAME);
      chk("t5_ft_cnt", ft_cnt, 1);
      chk("t5_ft_pos", ft_pos, FRAME - 1);

      // 6: reset during digit 2 of a 5959 frame
      align(16'h5959);
      for (int i = 0; i < 20; i++) cycle(1'b0, 16'h5959, 1'b1);
      cycle(1'b1, 16'h5959, 1'b1);
      chk("t6_rst_an", an, 4'hF);
      capture(16'h5959, 16'h5959, FRAME, 1'b1);
      chk("t6_z_d0", cap_seg[0], 7'h40);
      chk("t6_z_d1", cap_seg[1], 7'h40);
      chk("t6_z_d2", cap_seg[2], 7'h40);
      chk("t6_z_dp2", cap_dp[2], 1'b0);
      chk("t6_z_d3", cap_seg[3], 7'h7F);
      capture(16'h5959, 16'h5959, FRAME, 1'b1);
      chk("t6_d3", cap_seg[3], 7'h12);
      chk("t6_d0", cap_seg[0], 7'h10);

      // Randomized traffic, mostly valid BCD times, occasional resets and dark cycles
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            rtd = 16'($urandom);
         end else begin
            rtd = {4'($urandom_range(0, 5) * $urandom_range(0, 1)), 4'($urandom_range(0, 9)),
                   4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
         end
         ren = ($urandom_range(0, 9) != 0);
         rr  = ($urandom_range(0, 199) == 0);
         cycle(rr, rtd, ren);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
